mpmc11_port_arbiter: RTL and testbench

- Selects one pending command per cycle from up to 16 per-port request FIFOs and presents it to the mpmc11 memory state machine as a single mpmc11_fifoe_t stream.
- Round-robin between ports, with one fixed high-priority port (video refresh).
- Supports a lock so ALU/CAS read-modify-write sequences from one port are not interleaved.
- Sits between the per-port command FIFOs and the mpmc11 controller input FIFO.

---
 rtl/mpmc11_port_arbiter_if.sv | 44 ++++
 rtl/mpmc11_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mpmc11_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mpmc11_port_arbiter_if.sv
// Command types and the port-side / controller-side bundle of the mpmc11 port arbiter.
// The package precedes the interface so both the arbiter and its users share one type set.
package mpmc11_arb_pkg;

  typedef struct packed {
    logic [4:0]   cmd;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic [3:0]          port;
    fta_cmd_request256_t req;
  } mpmc11_fifoe_t;

endpackage

interface mpmc11_port_arbiter_if
  import mpmc11_arb_pkg::*;
#(
  parameter int NPORT = 8
);
  logic [NPORT-1:0]    in_valid;
  fta_cmd_request256_t in_req [NPORT];
  logic [NPORT-1:0]    in_lock;
  logic [NPORT-1:0]    in_pop;
  logic                out_valid;
  logic                out_ready;
  mpmc11_fifoe_t       out_cmd;
  logic                lock_active;
  logic [3:0]          lock_port;

  modport master (
    output in_valid, in_req, in_lock, out_ready,
    input  in_pop, out_valid, out_cmd, lock_active, lock_port
  );

  modport slave (
    input  in_valid, in_req, in_lock, out_ready,
    output in_pop, out_valid, out_cmd, lock_active, lock_port
  );
endinterface

// File: rtl/mpmc11_port_arbiter.sv
// Per-port command arbiter for mpmc11: fixed high-priority port, round-robin, RMW lock.
// Defining MPMC11_ARB_STARVE_EN adds per-port wait counters that override priority.
module mpmc11_port_arbiter
  import mpmc11_arb_pkg::*;
#(
  parameter int NPORT      = 8,
  parameter int HIPRI_PORT = 0,
  parameter int LOCK_MAX   = 15
`ifdef MPMC11_ARB_STARVE_EN
  ,
  parameter int STARVE_MAX = 63
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpmc11_port_arbiter_if.slave bus
);

  localparam int CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  arb_state_e          state_q, state_d;
  logic [3:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]          lock_port_q, lock_port_d;
  logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                out_valid_q, out_valid_d;
  mpmc11_fifoe_t       out_cmd_q, out_cmd_d;

  logic [NPORT-1:0]    elig_s;
  logic [NPORT-1:0]    pop_s;
  logic                slot_free_s;
  logic                pick_s;
  logic                grant_s;
  logic                hipri_s;
  logic [3:0]          gnt_idx_s;
  logic                sel_lock_s;
  fta_cmd_request256_t sel_req_s;

`ifdef MPMC11_ARB_STARVE_EN
  logic [5:0] wait_cnt_q [NPORT];
  logic [5:0] wait_cnt_d [NPORT];
`endif

  assign slot_free_s = !out_valid_q || bus.out_ready;
  assign grant_s     = pick_s && slot_free_s;

  // Winner selection: starving port, then the fixed-priority port, then round-robin.
  always_comb begin
    pick_s    = 1'b0;
    hipri_s   = 1'b0;
    gnt_idx_s = 4'd0;
    elig_s    = '0;
    for (int i = 0; i < NPORT; i++) begin
      elig_s[i] = bus.in_valid[i] && ((state_q == ARB_IDLE) || (lock_port_q == 4'(i)));
    end
`ifdef MPMC11_ARB_STARVE_EN
    if (state_q == ARB_IDLE) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!pick_s && elig_s[i] && (wait_cnt_q[i] >= 6'(STARVE_MAX))) begin
          pick_s    = 1'b1;
          gnt_idx_s = 4'(i);
        end else begin
        end
      end
    end else begin
    end
`endif
    for (int i = 0; i < NPORT; i++) begin
      if (!pick_s && (i == HIPRI_PORT) && elig_s[i]) begin
        pick_s    = 1'b1;
        hipri_s   = 1'b1;
        gnt_idx_s = 4'(i);
      end else begin
      end
    end
    for (int k = 0; k < NPORT; k++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!pick_s && elig_s[i] && (((int'(rr_ptr_q) + k) % NPORT) == i)) begin
          pick_s    = 1'b1;
          gnt_idx_s = 4'(i);
        end else begin
        end
      end
    end
  end

  // Pop strobe, output slot, round-robin pointer and lock state machine.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_port_d = lock_port_q;
    lock_cnt_d  = lock_cnt_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    pop_s       = '0;
    sel_req_s   = '0;
    sel_lock_s  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant_s && (gnt_idx_s == 4'(i))) begin
        pop_s[i]   = 1'b1;
        sel_req_s  = bus.in_req[i];
        sel_lock_s = bus.in_lock[i];
      end else begin
      end
    end
    if (grant_s) begin
      out_valid_d    = 1'b1;
      out_cmd_d.port = gnt_idx_s;
      out_cmd_d.req  = sel_req_s;
      if (!hipri_s) begin
        rr_ptr_d = (gnt_idx_s == 4'(NPORT - 1)) ? 4'd0 : gnt_idx_s + 4'd1;
      end else begin
      end
      case (state_q)
        ARB_IDLE: begin
          if (sel_lock_s) begin
            lock_port_d = gnt_idx_s;
            lock_cnt_d  = CW'(1);
            state_d     = (LOCK_MAX > 1) ? ARB_LOCK : ARB_IDLE;
          end else begin
          end
        end
        ARB_LOCK: begin
          // The grant that brings the count to LOCK_MAX ends the lock even if more is queued.
          if (!sel_lock_s || ((lock_cnt_q + CW'(1)) >= CW'(LOCK_MAX))) begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= 4'd0;
      lock_port_q <= 4'd0;
      lock_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_port_q <= lock_port_d;
      lock_cnt_q  <= lock_cnt_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
    end
  end

`ifdef MPMC11_ARB_STARVE_EN
  // Wait counters saturate at the 6-bit maximum and clear on grant or an empty FIFO.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      if (!bus.in_valid[i] || pop_s[i]) begin
        wait_cnt_d[i] = 6'd0;
      end else if (wait_cnt_q[i] != 6'h3f) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 6'd1;
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORT; i++) begin
        wait_cnt_q[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end
`endif

  assign bus.in_pop      = pop_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_cmd     = out_cmd_q;
  assign bus.lock_active = (state_q == ARB_LOCK);
  assign bus.lock_port   = lock_port_q;

endmodule

// File: tb/tb_mpmc11_port_arbiter.sv
// Directed bench for mpmc11_port_arbiter: per-port request tables, expected commands
// queued at grant time and compared when they appear on out_cmd.
module tb_mpmc11_port_arbiter;
  import mpmc11_arb_pkg::*;

  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  int            tests = 0;
  int            fails = 0;
  int            seq [NP];
  mpmc11_fifoe_t sb [$];
  mpmc11_fifoe_t last_exp;

  mpmc11_port_arbiter_if #(.NPORT(NP)) bus ();

  mpmc11_port_arbiter #(
    .NPORT(NP),
    .HIPRI_PORT(0),
    .LOCK_MAX(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic fta_cmd_request256_t mk_req(input int p, input int s);
    fta_cmd_request256_t r;
    r     = '0;
    r.cmd = 5'(p + 1);
    r.tid = 8'(s);
    r.adr = 32'(p * 4096 + s * 32);
    r.sel = 32'hffff_0000 | 32'(p);
    r.dat = {8{32'(p * 1000 + s)}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] lk);
    bus.in_valid = v;
    bus.in_lock  = lk;
    for (int i = 0; i < NP; i++) bus.in_req[i] = mk_req(i, seq[i]);
  endtask

  // gp: expected granted port (-1 none); ev/el: out_valid/lock_active after the edge; lp: lock_port (-1 skip)
  task automatic step(input int gp, input logic ev, input logic el, input int lp);
    logic [NP-1:0] ep;
    mpmc11_fifoe_t e;
    ep = '0;
    #4;
    if (gp >= 0) begin
      ep[gp] = 1'b1;
      e.port = 4'(gp);
      e.req  = mk_req(gp, seq[gp]);
      sb.push_back(e);
    end
    chk($sformatf("in_pop_p%0d", gp), bus.in_pop, ep);
    @(posedge clk);
    #1;
    if (gp >= 0) begin
      seq[gp]++;
      drive(bus.in_valid, bus.in_lock);
    end
    chk("out_valid", bus.out_valid, ev);
    chk("lock_active", bus.lock_active, el);
    if (lp >= 0) chk("lock_port", bus.lock_port, 4'(lp));
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      chk($sformatf("out_cmd_p%0d", gp), bus.out_cmd, last_exp);
    end else if (ev) begin
      chk("out_cmd_hold", bus.out_cmd, last_exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    last_exp      = '0;
    for (int i = 0; i < NP; i++) seq[i] = 0;
    drive('0, '0);
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_pop", bus.in_pop, 8'h00);
    chk("rst_lock_active", bus.lock_active, 1'b0);
    chk("rst_lock_port", bus.lock_port, 4'd0);
    chk("rst_out_cmd", bus.out_cmd, 512'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin over ports 1, 3, 5
    drive(8'b0010_1010, 8'h00);
    step(1, 1'b1, 1'b0, -1);
    step(3, 1'b1, 1'b0, -1);
    step(5, 1'b1, 1'b0, -1);
    step(1, 1'b1, 1'b0, -1);
    step(3, 1'b1, 1'b0, -1);
    step(5, 1'b1, 1'b0, -1);
    drive(8'h00, 8'h00);
    step(-1, 1'b0, 1'b0, -1);

    // High-priority port 0 dominates; its grants leave the pointer at 6
    drive(8'b1000_0101, 8'h00);
    step(0, 1'b1, 1'b0, -1);
    step(0, 1'b1, 1'b0, -1);
    step(0, 1'b1, 1'b0, -1);
    drive(8'b1000_0100, 8'h00);
    step(7, 1'b1, 1'b0, -1);
    step(2, 1'b1, 1'b0, -1);
    drive(8'h00, 8'h00);
    step(-1, 1'b0, 1'b0, -1);

    // Lock on port 4 while port 6 waits, including an empty-FIFO gap
    drive(8'b0101_0000, 8'b0001_0000);
    step(4, 1'b1, 1'b1, 4);
    drive(8'b0100_0000, 8'b0001_0000);
    step(-1, 1'b0, 1'b1, 4);
    drive(8'b0101_0000, 8'b0001_0000);
    step(4, 1'b1, 1'b1, 4);
    drive(8'b0101_0000, 8'h00);
    step(4, 1'b1, 1'b0, -1);
    drive(8'b0100_0000, 8'h00);
    step(6, 1'b1, 1'b0, -1);
    drive(8'h00, 8'h00);
    step(-1, 1'b0, 1'b0, -1);

    // Back-pressure: command held for 4 cycles, then grant in the accepting cycle
    drive(8'b0001_0000, 8'h00);
    step(4, 1'b1, 1'b0, -1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step(-1, 1'b1, 1'b0, -1);
    bus.out_ready = 1'b1;
    step(4, 1'b1, 1'b0, -1);
    drive(8'h00, 8'h00);
    step(-1, 1'b0, 1'b0, -1);

    // Port 2 keeps in_lock high: released after 15 grants, then port 5 by round-robin
    drive(8'b0000_0100, 8'b0000_0100);
    step(2, 1'b1, 1'b1, 2);
    drive(8'b0010_0100, 8'b0000_0100);
    for (int k = 2; k < 15; k++) step(2, 1'b1, 1'b1, 2);
    step(2, 1'b1, 1'b0, -1);
    step(5, 1'b1, 1'b0, -1);
    step(2, 1'b1, 1'b1, 2);
    drive(8'h00, 8'b0000_0100);
    step(-1, 1'b0, 1'b1, 2);

    // Reset while locked clears the lock and the held command
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_lock_active", bus.lock_active, 1'b0);
    chk("mid_rst_lock_port", bus.lock_port, 4'd0);
    chk("mid_rst_out_cmd", bus.out_cmd, 512'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(8'b0010_0100, 8'h00);
    step(2, 1'b1, 1'b0, -1);
    step(5, 1'b1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
